// File: rtl/fp_cmp_stream_if.sv
// fp_cmp_stream_if: operand/result bundle and valid/ready handshake of the pipelined FP compare unit.
interface fp_cmp_stream_if #(
  parameter int ExpWidth = 8,
  parameter int ManWidth = 23,
  parameter int NumLanes = 4,
  parameter int TagWidth = 4
);
  localparam int DataWidth = ExpWidth + ManWidth + 3;
  logic                          in_valid_i;
  logic                          in_ready_o;
  logic [2:0]                    op_i;
  logic [TagWidth-1:0]           tag_i;
  logic [NumLanes*DataWidth-1:0] operand_a_i;
  logic [NumLanes*DataWidth-1:0] operand_b_i;
  logic                          out_valid_o;
  logic                          out_ready_i;
  logic [NumLanes*DataWidth-1:0] result_o;
  logic [NumLanes-1:0]           unordered_o;
  logic [TagWidth-1:0]           tag_o;
  logic                          illegal_op_o;
  logic                          sticky_unord_o;
  logic                          sticky_clr_i;
  modport master (
    output in_valid_i, op_i, tag_i, operand_a_i, operand_b_i, out_ready_i, sticky_clr_i,
    input  in_ready_o, out_valid_o, result_o, unordered_o, tag_o, illegal_op_o, sticky_unord_o
  );
  modport slave (
    input  in_valid_i, op_i, tag_i, operand_a_i, operand_b_i, out_ready_i, sticky_clr_i,
    output in_ready_o, out_valid_o, result_o, unordered_o, tag_o, illegal_op_o, sticky_unord_o
  );
endinterface

// File: rtl/fp_cmp_stream.sv
// fp_cmp_stream: elastic multi-lane FloPoCo-format compare/min/max pipeline with sticky unordered flag.
module fp_cmp_stream #(
  parameter int ExpWidth  = 8,
  parameter int ManWidth  = 23,
  parameter int NumLanes  = 4,
  parameter int NumStages = 2,
  parameter int TagWidth  = 4
) (
  input logic            clk_i,
  input logic            rst_ni,
  fp_cmp_stream_if.slave bus
);
  localparam int DataWidth = ExpWidth + ManWidth + 3;
  localparam int MagWidth  = ExpWidth + ManWidth;
  localparam int PayWidth  = NumLanes * DataWidth + NumLanes + TagWidth + 1;
  localparam logic [DataWidth-1:0] CanonNan = {2'b11, {(DataWidth-2){1'b0}}};

  logic [NumLanes-1:0][DataWidth-1:0] res_c;
  logic [NumLanes-1:0]                unord_c;
  logic                               illegal_c;
  logic [PayWidth-1:0]                pay_c;
  logic [PayWidth-1:0]                pay_out;

  assign illegal_c = bus.op_i[2:1] == 2'b11;

  for (genvar l = 0; l < NumLanes; l++) begin : g_lane
    logic [DataWidth-1:0] a, b, pick;
    logic [MagWidth-1:0]  ma, mb;
    logic [2:0]           ra, rb;
    logic sa, sb, nan_a, nan_b, za, zb, unord, lt_ab, lt_ba, eq, a_lt_b, b_lt_a, pred;
    assign a     = bus.operand_a_i[l*DataWidth +: DataWidth];
    assign b     = bus.operand_b_i[l*DataWidth +: DataWidth];
    assign sa    = a[DataWidth-3];
    assign sb    = b[DataWidth-3];
    assign ma    = a[MagWidth-1:0];
    assign mb    = b[MagWidth-1:0];
    assign nan_a = &a[DataWidth-1 -: 2];
    assign nan_b = &b[DataWidth-1 -: 2];
    assign za    = a[DataWidth-1 -: 2] == 2'b00;
    assign zb    = b[DataWidth-1 -: 2] == 2'b00;
    // class rank: -inf, -normal, zero, +normal, +inf; NaN lands on an inf rank but is masked by unord
    assign ra    = za ? 3'd2 : a[DataWidth-1] ? (sa ? 3'd0 : 3'd4) : (sa ? 3'd1 : 3'd3);
    assign rb    = zb ? 3'd2 : b[DataWidth-1] ? (sb ? 3'd0 : 3'd4) : (sb ? 3'd1 : 3'd3);
    assign lt_ab = ra != rb ? ra < rb : ra == 3'd3 ? ma < mb : ra == 3'd1 && ma > mb;
    assign lt_ba = ra != rb ? rb < ra : ra == 3'd3 ? mb < ma : ra == 3'd1 && mb > ma;
    assign eq    = !lt_ab && !lt_ba;
    assign unord = nan_a || nan_b;
    // min/max order splits the zero class so that -0 sorts below +0
    assign a_lt_b = lt_ab || (za && zb && sa && !sb);
    assign b_lt_a = lt_ba || (za && zb && sb && !sa);
    assign pick  = unord ? (nan_a && nan_b ? CanonNan : nan_a ? b : a)
                         : ((bus.op_i[0] ? a_lt_b : b_lt_a) ? b : a);
    assign pred  = bus.op_i[1:0] == 2'b11 ? unord
                 : !unord && (bus.op_i[1] ? eq : lt_ab || (bus.op_i[0] && eq));
    assign res_c[l]   = illegal_c ? '0 : bus.op_i[2] ? pick : DataWidth'(pred);
    assign unord_c[l] = unord;
  end

  assign pay_c = {illegal_c, bus.tag_i, unord_c, res_c};
  assign {bus.illegal_op_o, bus.tag_o, bus.unordered_o, bus.result_o} = pay_out;

  if (NumStages == 0) begin : g_comb
    assign pay_out         = pay_c;
    assign bus.out_valid_o = bus.in_valid_i;
    assign bus.in_ready_o  = bus.out_ready_i;
  end else begin : g_pipe
    logic [NumStages-1:0]               v_q, v_d, v_in, rdy;
    logic [NumStages-1:0][PayWidth-1:0] pay_q, pay_d, pay_in;
    logic                               acc;
    assign v_in   = NumStages'({v_q, bus.in_valid_i});
    assign pay_in = (NumStages*PayWidth)'({pay_q, pay_c});
    always_comb begin
      acc   = bus.out_ready_i;
      rdy   = '0;
      v_d   = v_q;
      pay_d = pay_q;
      for (int k = NumStages - 1; k >= 0; k--) begin
        acc    = acc || !v_q[k];
        rdy[k] = acc;
      end
      for (int k = 0; k < NumStages; k++) begin
        v_d[k]   = rdy[k] ? v_in[k] : v_q[k];
        pay_d[k] = rdy[k] && v_in[k] ? pay_in[k] : pay_q[k];
      end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        v_q   <= '0;
        pay_q <= '0;
      end else begin
        v_q   <= v_d;
        pay_q <= pay_d;
      end
    end
    assign pay_out         = pay_q[NumStages-1];
    assign bus.out_valid_o = v_q[NumStages-1];
    assign bus.in_ready_o  = rdy[0];
  end

  logic sticky_q, sticky_d;
  assign sticky_d = (bus.out_valid_o && bus.out_ready_i && |bus.unordered_o) || (sticky_q && !bus.sticky_clr_i);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sticky_q <= 1'b0;
    else sticky_q <= sticky_d;
  end
  assign bus.sticky_unord_o = sticky_q;
endmodule

// File: tb/tb_fp_cmp_stream.sv
// tb_fp_cmp_stream: directed scoreboard bench for fp_cmp_stream (2-stage and combinational builds).
module tb_fp_cmp_stream;
  localparam logic [33:0] ONE  = 34'h1_3F80_0000, TWO = 34'h1_4000_0000;
  localparam logic [33:0] M1   = 34'h1_BF80_0000, M2  = 34'h1_C000_0000;
  localparam logic [33:0] PZ   = 34'h0_0000_0000, NZ  = 34'h0_8000_0000;
  localparam logic [33:0] QNAN = 34'h3_0000_0000, PINF = 34'h2_0000_0000, NINF = 34'h2_8000_0000;
  localparam logic [33:0] T    = 34'd1, F = 34'd0;

  typedef struct {
    logic [135:0] res;
    logic [3:0]   unord;
    logic [3:0]   tag;
    logic         ill;
    int           cyc;
    logic         lat;
  } ent_t;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_cmp_stream_if bus ();
  fp_cmp_stream_if bus0 ();
  fp_cmp_stream u_dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  fp_cmp_stream #(.NumStages(0)) u_dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(bus0));

  int n_chk = 0, n_fail = 0, ncyc = 0, n_out = 0, run = 0, max_run = 0, t0 = 0, n0 = 0;
  logic accepted = 1'b0, rnd_rdy = 1'b0, held_v = 1'b0;
  logic [135:0] held_res;
  logic [3:0] held_tag, held_u;
  ent_t pend, sb[$];

  function automatic logic [135:0] p4(input logic [33:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [135:0] bpa(input int i);
    return p4(ONE + 34'(i), ONE + 34'(i + 16), ONE + 34'(i + 32), ONE + 34'(i + 48));
  endfunction

  task automatic check(input string name, input logic [135:0] got, input logic [135:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // one clock: monitor at the falling edge, return just after the rising edge
  task automatic tick();
    ent_t e;
    @(negedge clk);
    if (bus.out_valid_o && bus.out_ready_i) begin
      n_out++;
      check("out_has_expected", 136'(sb.size() != 0), 136'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("result", bus.result_o, e.res);
        check("unordered", 136'(bus.unordered_o), 136'(e.unord));
        check("tag", 136'(bus.tag_o), 136'(e.tag));
        check("illegal_op", 136'(bus.illegal_op_o), 136'(e.ill));
        if (e.lat) check("latency", 136'(ncyc - e.cyc), 136'(2));
      end
    end
    if (held_v) begin
      check("stall_valid", 136'(bus.out_valid_o), 136'(1));
      check("stall_result", bus.result_o, held_res);
      check("stall_tag", 136'(bus.tag_o), 136'(held_tag));
      check("stall_unord", 136'(bus.unordered_o), 136'(held_u));
    end
    held_v   = bus.out_valid_o && !bus.out_ready_i;
    held_res = bus.result_o;
    held_tag = bus.tag_o;
    held_u   = bus.unordered_o;
    if (bus.in_valid_i && bus.in_ready_o) begin
      accepted = 1'b1;
      pend.cyc = ncyc;
      sb.push_back(pend);
      run = bus.out_ready_i ? 0 : run + 1;
      if (run > max_run) max_run = run;
    end else if (bus.out_ready_i) run = 0;
    @(posedge clk);
    #1;
    ncyc++;
    if (rnd_rdy) bus.out_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [2:0] op, input logic [3:0] tag, input logic [135:0] a, b, er,
                      input logic [3:0] eu, input logic eill, input logic lat);
    bus.in_valid_i  = 1'b1;
    bus.op_i        = op;
    bus.tag_i       = tag;
    bus.operand_a_i = a;
    bus.operand_b_i = b;
    pend = '{res: er, unord: eu, tag: tag, ill: eill, cyc: 0, lat: lat};
    accepted = 1'b0;
    for (int i = 0; i < 100 && !accepted; i++) tick();
    check("accept", 136'(accepted), 136'(1));
  endtask

  task automatic drain();
    bus.in_valid_i = 1'b0;
    for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
    check("drain_empty", 136'(sb.size()), 136'(0));
  endtask

  initial begin
    bus.in_valid_i = 1'b0; bus.op_i = '0; bus.tag_i = '0; bus.operand_a_i = '0; bus.operand_b_i = '0;
    bus.out_ready_i = 1'b1; bus.sticky_clr_i = 1'b0;
    bus0.in_valid_i = 1'b0; bus0.op_i = '0; bus0.tag_i = '0; bus0.operand_a_i = '0; bus0.operand_b_i = '0;
    bus0.out_ready_i = 1'b1; bus0.sticky_clr_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 136'(bus.out_valid_o), 136'(0));
    check("rst_in_ready", 136'(bus.in_ready_o), 136'(1));
    check("rst_result", bus.result_o, 136'(0));
    check("rst_tag", 136'(bus.tag_o), 136'(0));
    check("rst_illegal", 136'(bus.illegal_op_o), 136'(0));
    check("rst_sticky", 136'(bus.sticky_unord_o), 136'(0));
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", 136'(bus.in_ready_o), 136'(1));
    // basic LT with latency check
    send(3'b000, 4'd5, p4(ONE, ONE, ONE, ONE), p4(TWO, TWO, TWO, TWO), p4(T, T, T, T), 4'b0000, 1'b0, 1'b1);
    drain();
    check("sticky_ordered_only", 136'(bus.sticky_unord_o), 136'(0));
    // special-value MIN / MAX
    send(3'b100, 4'd1, p4(NZ, 34'h3_1234_5678, TWO, PZ), p4(PZ, QNAN, ONE, NZ),
         p4(NZ, QNAN, ONE, NZ), 4'b0010, 1'b0, 1'b0);
    send(3'b101, 4'd2, p4(QNAN, M1, M1, 34'h0_0000_0001), p4(M1, 34'h3_FFFF_FFFF, M2, PZ),
         p4(M1, M1, M1, 34'h0_0000_0001), 4'b0011, 1'b0, 1'b0);
    drain();
    check("sticky_set", 136'(bus.sticky_unord_o), 136'(1));
    // predicates with don't-care fields, at full throughput
    t0 = ncyc;
    send(3'b010, 4'd3, p4(34'h0_0000_0001, PINF, ONE, QNAN), p4(NZ, 34'h2_7F80_1234, TWO, QNAN),
         p4(T, T, F, F), 4'b1000, 1'b0, 1'b0);
    send(3'b000, 4'd4, p4(NINF, M1, M2, NZ), p4(34'h1_FF7F_FFFF, M2, M1, PZ), p4(T, F, T, F), 4'b0000, 1'b0, 1'b0);
    send(3'b001, 4'd6, p4(NZ, TWO, QNAN, ONE), p4(PZ, ONE, ONE, ONE), p4(T, F, F, T), 4'b0100, 1'b0, 1'b0);
    send(3'b011, 4'd8, p4(QNAN, ONE, ONE, PINF), p4(ONE, QNAN, TWO, NINF), p4(T, T, F, F), 4'b0011, 1'b0, 1'b0);
    send(3'b110, 4'd9, p4(QNAN, ONE, ONE, ONE), p4(ONE, TWO, TWO, TWO), 136'(0), 4'b0001, 1'b1, 1'b0);
    send(3'b111, 4'd10, p4(ONE, ONE, ONE, ONE), p4(TWO, TWO, TWO, TWO), 136'(0), 4'b0000, 1'b1, 1'b0);
    check("throughput", 136'(ncyc - t0), 136'(6));
    drain();
    // sticky: clear coinciding with an unordered transfer loses
    bus.out_ready_i = 1'b0;
    send(3'b011, 4'd11, p4(QNAN, ONE, ONE, ONE), p4(ONE, ONE, ONE, ONE), p4(T, F, F, F), 4'b0001, 1'b0, 1'b0);
    bus.in_valid_i = 1'b0;
    for (int i = 0; i < 10 && !bus.out_valid_o; i++) tick();
    bus.sticky_clr_i = 1'b1;
    bus.out_ready_i  = 1'b1;
    tick();
    bus.sticky_clr_i = 1'b0;
    check("sticky_set_wins", 136'(bus.sticky_unord_o), 136'(1));
    bus.sticky_clr_i = 1'b1;
    tick();
    bus.sticky_clr_i = 1'b0;
    check("sticky_clear", 136'(bus.sticky_unord_o), 136'(0));
    check("sticky_sb_empty", 136'(sb.size()), 136'(0));
    // back-pressure stream
    n0 = n_out; max_run = 0; run = 0; rnd_rdy = 1'b1;
    for (int i = 0; i < 10; i++)
      send(3'b101, 4'(i), bpa(i), p4(ONE, ONE, ONE, ONE), bpa(i), 4'b0000, 1'b0, 1'b0);
    drain();
    rnd_rdy = 1'b0;
    bus.out_ready_i = 1'b1;
    check("bp_count", 136'(n_out - n0), 136'(10));
    check("bp_max_run", 136'(max_run <= 2), 136'(1));
    // reset with two bundles in flight
    bus.out_ready_i = 1'b0;
    send(3'b000, 4'd12, p4(ONE, ONE, ONE, ONE), p4(TWO, TWO, TWO, TWO), p4(T, T, T, T), 4'b0000, 1'b0, 1'b0);
    send(3'b000, 4'd13, p4(ONE, ONE, ONE, ONE), p4(TWO, TWO, TWO, TWO), p4(T, T, T, T), 4'b0000, 1'b0, 1'b0);
    bus.in_valid_i = 1'b0;
    check("pre_rst_valid", 136'(bus.out_valid_o), 136'(1));
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 136'(bus.out_valid_o), 136'(0));
    check("async_rst_ready", 136'(bus.in_ready_o), 136'(1));
    sb.delete();
    held_v = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready_i = 1'b1;
    repeat (5) tick();
    check("no_stale_out", 136'(bus.out_valid_o), 136'(0));
    check("no_stale_count", 136'(sb.size()), 136'(0));
    // combinational build
    bus0.op_i = 3'b000; bus0.tag_i = 4'hA;
    bus0.operand_a_i = p4(ONE, ONE, ONE, ONE);
    bus0.operand_b_i = p4(TWO, TWO, TWO, TWO);
    bus0.in_valid_i = 1'b1;
    #1;
    check("s0_valid", 136'(bus0.out_valid_o), 136'(1));
    check("s0_result", bus0.result_o, p4(T, T, T, T));
    check("s0_tag", 136'(bus0.tag_o), 136'(4'hA));
    check("s0_ready", 136'(bus0.in_ready_o), 136'(1));
    bus0.out_ready_i = 1'b0;
    #1;
    check("s0_ready_low", 136'(bus0.in_ready_o), 136'(0));
    bus0.in_valid_i = 1'b0;
    #1;
    check("s0_valid_low", 136'(bus0.out_valid_o), 136'(0));
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/fp_cmp_stream.md
# fp_cmp_stream

Pipelined, multi-lane comparator and min/max unit for FloPoCo-format floating-point operands, with valid/ready handshake, back-pressure, tag pass-through and a sticky unordered flag. It sits on the FP datapath between the operand-issue stage and the writeback arbiter. It replaces the unclocked single-lane compare wrapper wherever a registered, throttleable result is needed. Comparison logic is native RTL; no FloPoCo core is instantiated.

## Interface
- ExpWidth, 8: exponent field width.
- ManWidth, 23: fraction field width.
- DataWidth, ExpWidth+ManWidth+3: operand width. Derived; do not override.
- NumLanes, 4: independent lanes sharing one handshake.
- NumStages, 2: register stages, 0..4. 0 is a combinational path.
- TagWidth, 4: opaque tag width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous reset, active low.
- in_valid_i  in  1  operand bundle valid.
- in_ready_o  out  1  unit accepts the bundle.
- op_i  in  3  operation: 000 LT, 001 LE, 010 EQ, 011 UNORD, 100 MIN, 101 MAX, 11x reserved.
- tag_i  in  TagWidth  returned unchanged with the result.
- operand_a_i, operand_b_i  in  NumLanes×DataWidth  per-lane operands.
- out_valid_o  out  1  result bundle valid.
- out_ready_i  in  1  consumer accepts the result.
- result_o  out  NumLanes×DataWidth  per-lane result.
- unordered_o  out  NumLanes  per-lane: at least one operand is NaN.
- tag_o  out  TagWidth  tag of the current result.
- illegal_op_o  out  1  op was reserved.
- sticky_unord_o  out  1  sticky OR of unordered over accepted outputs.
- sticky_clr_i  in  1  synchronous clear of the sticky flag.

## Operation
Operand format, MSB first:
- exc[1:0]: 00 zero, 01 normal, 10 infinity, 11 NaN.
- sign.
- exp[ExpWidth-1:0].
- frac[ManWidth-1:0].

For zero, infinity and NaN, the exp and frac fields are don't-care and must not affect any result.

Ordering:
- NaN is unordered.
- Otherwise order is: -inf < negative normals < zeros < positive normals < +inf.
- Normals of the same sign compare by the {exp,frac} magnitude; the order is reversed for negative.
- Predicates treat +0 and -0 as equal.

Predicate ops (LT, LE, EQ, UNORD):
- result bit 0 is the predicate; upper bits are 0.
- LT, LE and EQ are 0 whenever the lane is unordered.

MIN/MAX:
- Result is the selected operand, bit-exact.
- One NaN: return the other operand.
- Both NaN: return the canonical NaN {2'b11, all zero}.
- For zeros of opposite sign, -0 < +0.
- Equal operands: return operand_a.

Reserved op: result all zero, unordered_o still valid, illegal_op_o = 1.

unordered_o is valid for every op.

## Timing
- Handshake: a transfer occurs when valid and ready are both high in the same cycle.
  - Once out_valid_o is high, it stays high until the transfer.
  - result_o and tag_o hold stable while out_valid_o is high and out_ready_i is low.
- NumStages = N ≥ 1:
  - Elastic pipeline of N stages; each stage has a valid bit.
  - Latency is N cycles from the input transfer to out_valid_o.
  - Stage k loads when it is empty or stage k+1 accepts its contents.
  - in_ready_o = !stage0_valid || stage0 advances. This is a combinational path from out_ready_i.
  - Full throughput: one bundle per cycle with out_ready_i held high.
  - No bubble is inserted on resume after a stall.
  - Ordering is strict FIFO.
- NumStages = 0: out_valid_o = in_valid_i, in_ready_o = out_ready_i, all outputs combinational.
- Sticky flag:
  - Set when an output transfer has any unordered_o bit high.
  - sticky_clr_i clears it on the next edge.
  - If set and clear occur in the same cycle, set wins.
- Reset (rst_ni low, async): every stage valid = 0, out_valid_o = 0, data and tag registers = 0, illegal_op_o = 0, sticky_unord_o = 0.
  - in_ready_o = 1 during and after reset.
  - Reset mid-stream drops all in-flight bundles; no partial output follows.

## Test plan
Default parameters throughout.
- Basic compare, all four lanes, op LT:
  - Stimulus: a = 34'h1_3F80_0000 (1.0), b = 34'h1_4000_0000 (2.0).
  - Required: result = 1 on every lane, unordered_o = 0, tag echoed, out_valid_o exactly 2 cycles after the input transfer.
- Special-value MIN/MAX:
  - MIN(-0 = 34'h0_8000_0000, +0 = 34'h0_0000_0000) returns 34'h0_8000_0000.
  - MAX(NaN = 34'h3_0000_0000, -1.0 = 34'h1_BF80_0000) returns 34'h1_BF80_0000 with unordered_o = 1.
  - MIN(NaN 34'h3_1234_5678, NaN) returns 34'h3_0000_0000.
- Don't-care fields:
  - EQ(34'h0_0000_0001, 34'h0_8000_0000) = 1.
  - LT(-inf 34'h2_8000_0000, 34'h1_FF7F_FFFF) = 1.
  - Reserved op 3'b110 gives result 0 with illegal_op_o = 1.
- Back-pressure:
  - Stimulus: stream 10 bundles with tags 0..9 while out_ready_i toggles randomly.
  - Required: tags emerge 0..9 in order; no loss or duplication; outputs stable during stalls; at most 2 bundles accepted while out_ready_i stays low.
- Sticky flag:
  - An output transfer with a NaN lane sets sticky_unord_o.
  - sticky_clr_i in the same cycle as another unordered transfer leaves it 1.
  - sticky_clr_i alone clears it.
- Reset and degenerate pipeline:
  - Assert rst_ni low with 2 bundles in flight: out_valid_o goes 0 at once, and no stale bundle appears after release.
  - Repeat the basic compare with NumStages = 0: result appears in the same cycle.
